// File: rtl/lead_sign_norm.sv
// Leading-sign / leading-zero detector with normalising shift.
// Detection runs in the first pipeline stage. Count encoding and the
// normalising shift run in the last stage. With LATENCY = 1 both happen
// in the same stage. Every stage has a valid bit and uses elastic
// handshaking, so a full pipeline can accept and emit in the same cycle.
module lead_sign_norm #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int SPEED   = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       mode_i,
    input  logic [WIDTH-1:0]           a_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [WIDTH-1:0]           z_o,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o,
    output logic [WIDTH-1:0]           norm_o,
    output logic                       all_o
);

    localparam int CW = $clog2(WIDTH+1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic             mode;
        logic [WIDTH-1:0] z;
        logic             all;
    } det_t;

    // OR-prefix over r, taken from index 0 upward. SPEED selects only the
    // network shape. Every shape gives the same result.
    function automatic logic [WIDTH-1:0] prefix_or(input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] t;
        t = r;
        if (SPEED == 1) begin
            // Brent-Kung: an up-sweep builds the span roots, then a
            // down-sweep fills in the gaps between them.
            for (int unsigned s = 2; s < 2 * WIDTH; s = s * 2)
                for (int unsigned j = s - 1; j < WIDTH; j = j + s)
                    t[j] = t[j] | t[j - s / 2];
            for (int unsigned s = (1 << $clog2(WIDTH)); s >= 2; s = s / 2)
                for (int unsigned j = s + s / 2 - 1; j < WIDTH; j = j + s)
                    t[j] = t[j] | t[j - s / 2];
        end else if (SPEED == 2) begin
            // Sklansky: at each level the upper half of every block takes
            // the OR of its lower half. The source bit is never rewritten
            // at the same level.
            for (int unsigned s = 1; s < WIDTH; s = s * 2)
                for (int unsigned j = 0; j < WIDTH; j++)
                    if ((j & s) != 0)
                        t[j] = t[j] | t[(j & ~(s - 1)) - 1];
        end else begin
            for (int unsigned j = 1; j < WIDTH; j++)
                t[j] = t[j] | t[j - 1];
        end
        return t;
    endfunction

    // Returns the one-hot position of the first bit that differs from the
    // sign bit (mode 0) or of the first set bit (mode 1), scanning from the MSB.
    function automatic det_t detect(input logic [WIDTH-1:0] a, input logic mode);
        logic [WIDTH-1:0] x, r, p, f;
        det_t d;
        // In mode 0 the MSB compares against itself and always becomes 0.
        x = mode ? a : (a ^ {WIDTH{a[WIDTH-1]}});
        for (int unsigned j = 0; j < WIDTH; j++)
            r[j] = x[WIDTH-1-j];
        p = prefix_or(r);
        f = r & ~(p << 1);
        for (int unsigned j = 0; j < WIDTH; j++)
            d.z[WIDTH-1-j] = f[j];
        d.a    = a;
        d.mode = mode;
        d.all  = ~p[WIDTH-1];
        return d;
    endfunction

    // Converts the one-hot position into the leading count.
    function automatic logic [CW-1:0] encode(input det_t d);
        logic [CW-1:0] c;
        c = '0;
        if (d.all) begin
            c = d.mode ? CW'(WIDTH) : CW'(WIDTH - 1);
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++)
                if (d.z[i])
                    c = c | (d.mode ? CW'(WIDTH - 1 - i) : CW'(WIDTH - 2 - i));
        end
        return c;
    endfunction

    logic [LATENCY-1:0] v_q;
    logic [LATENCY-1:0] ld;
    logic [LATENCY-1:0] vin;
    det_t               det_in;
    det_t               last_d;
    logic               last_v;
    logic [CW-1:0]      fin_cnt;
    logic [WIDTH-1:0]   fin_norm;
    logic [WIDTH-1:0]   z_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   norm_q;
    logic               all_q;

    // A stage can load when it is empty or when its content moves on this
    // cycle. The check starts at the output and works back to the input.
    always_comb begin : flow
        logic [LATENCY:0] g;
        g[LATENCY] = ready_i;
        for (int unsigned k = LATENCY; k > 0; k--)
            g[k-1] = ~v_q[k-1] | g[k];
        ld     = g[LATENCY-1:0];
        vin[0] = valid_i;
        for (int unsigned k = 1; k < LATENCY; k++)
            vin[k] = v_q[k-1];
    end

    assign ready_o = ld[0];
    assign valid_o = v_q[LATENCY-1];

    // Stage valid bits. Reset empties the whole pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= '0;
        end else begin
            for (int unsigned k = 0; k < LATENCY; k++)
                if (ld[k]) v_q[k] <= vin[k];
        end
    end

    // First-stage detection of the incoming operand.
    always_comb det_in = detect(a_i, mode_i);

    if (LATENCY > 1) begin : g_det
        det_t det_q [LATENCY-1];

        // Detection payload stages before the final stage.
        always_ff @(posedge clk_i) begin
            if (ld[0] && valid_i) det_q[0] <= det_in;
            for (int unsigned k = 1; k < LATENCY - 1; k++)
                if (ld[k] && v_q[k-1]) det_q[k] <= det_q[k-1];
        end

        assign last_d = det_q[LATENCY-2];
        assign last_v = v_q[LATENCY-2];
    end else begin : g_comb
        assign last_d = det_in;
        assign last_v = valid_i;
    end

    // Final-stage count encoding and normalising shift.
    always_comb begin
        fin_cnt  = encode(last_d);
        fin_norm = last_d.a << fin_cnt;
    end

    // Output registers. They hold their value while the output is stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            z_q    <= '0;
            cnt_q  <= '0;
            norm_q <= '0;
            all_q  <= 1'b0;
        end else if (ld[LATENCY-1] && last_v) begin
            z_q    <= last_d.z;
            cnt_q  <= fin_cnt;
            norm_q <= fin_norm;
            all_q  <= last_d.all;
        end
    end

    assign z_o    = z_q;
    assign cnt_o  = cnt_q;
    assign norm_o = norm_q;
    assign all_o  = all_q;

endmodule

// File: doc/lead_sign_norm.md
LEAD_SIGN_NORM -- requirements
Module: lead_sign_norm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width; legal values 4..64.
REQ-002 SHALL have parameter LATENCY, default 2, register stages from input accept to output valid; legal values 1..3.
REQ-003 SHALL have parameter SPEED, default 0, prefix-structure selector (0 serial, 1 Brent-Kung, 2 Sklansky); it changes timing only, never function.
REQ-004 SHALL derive localparam CW = $clog2(WIDTH+1) as the count width.
REQ-005 Port clk_i, input, 1: single clock; all state on rising edge.
REQ-006 Port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 Port valid_i, input, 1: input operand valid.
REQ-008 Port ready_o, output, 1: block can accept an operand this cycle.
REQ-009 Port mode_i, input, 1: 0 = leading-sign detect, 1 = leading-zero detect; sampled with the operand.
REQ-010 Port a_i, input, WIDTH: operand.
REQ-011 Port valid_o, output, 1: result valid.
REQ-012 Port ready_i, input, 1: downstream accepts result.
REQ-013 Port z_o, output, WIDTH: one-hot position of the first bit that differs from the sign bit (mode 0) or of the first '1' (mode 1); all zeros if no such bit.
REQ-014 Port cnt_o, output, CW: leading count.
REQ-015 Port norm_o, output, WIDTH: a_i shifted left by cnt_o, zero-filled.
REQ-016 Port all_o, output, 1: no differing bit found (operand all-sign in mode 0, all-zero in mode 1).

Function
REQ-017 Mode 0: cnt = number of bits below the MSB that equal the MSB before the first differing bit; range 0..WIDTH-1; z bit WIDTH-1 always 0.
REQ-018 Mode 0 all-sign operand: cnt = WIDTH-1, z = 0, all = 1, norm = a << (WIDTH-1).
REQ-019 Mode 1: cnt = number of leading zeros counted from the MSB inclusive; range 0..WIDTH; all-zero operand gives cnt = WIDTH, z = 0, norm = 0, all = 1.
REQ-020 Transfer in occurs on valid_i & ready_o; transfer out occurs on valid_o & ready_i.
REQ-021 Pipeline of LATENCY stages, each holding a valid bit plus payload; a stage loads when it is empty or the next stage (or the output for the last stage) advances in the same cycle.
REQ-022 ready_o = ~stage1_valid | stage1_advances; it depends combinationally on ready_i only through that chain, with no other path from input to output.
REQ-023 With ready_i held high, throughput SHALL be one result per cycle, and valid_o SHALL rise exactly LATENCY cycles after the accepting edge.
REQ-024 While valid_o & ~ready_i, all outputs SHALL hold stable and no accepted operand SHALL be dropped or duplicated; at most LATENCY operands are in flight.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 Simultaneous output transfer and input accept on a full pipeline SHALL be allowed (no bubble).
REQ-027 Work split: detection in stage 1; count encode and shift in the last stage (identical split when LATENCY = 1, combined).
REQ-028 Payload registers of empty stages MAY hold stale data; the outputs are defined only when valid_o = 1.

Reset
REQ-029 While rst_i = 1 at a clock edge, all stage valid bits SHALL clear; valid_o = 0, z_o = 0, cnt_o = 0, norm_o = 0, and all_o = 0 after that edge.
REQ-030 ready_o SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operands; no result for them appears afterwards.
REQ-032 An operand presented with valid_i during a reset cycle SHALL NOT be accepted.

Verification (WIDTH=8, LATENCY=2, ready_i=1 unless stated)
REQ-033 mode 0, a=0x05 -> 2 cycles later: z=0x04, cnt=4, norm=0x50, all=0.
REQ-034 mode 0, a=0xFA -> z=0x04, cnt=4, norm=0xA0, all=0; a=0xFF -> z=0x00, cnt=7, norm=0x80, all=1.
REQ-035 mode 1, a=0x05 -> z=0x04, cnt=5, norm=0xA0; a=0x00 -> z=0, cnt=8, norm=0, all=1; a=0x80 -> z=0x80, cnt=0, norm=0x80.
REQ-036 Back-to-back stream 0x01,0x02,0x40 in mode 0 with ready_i low for 3 cycles mid-stream -> cnts 6,5,0 delivered in order; ready_o low once 2 operands are held; no loss or duplication.
REQ-037 Reset pulse while 2 operands are in flight -> valid_o=0 the next cycle, ready_o=1, and no stale result afterwards.
REQ-038 Randomised compare of all outputs against a behavioural model for WIDTH in {4,8,13,32}, LATENCY in {1,2,3}, SPEED in {0,1,2}, with random valid_i and ready_i.
